// File: rtl/sd_read_arbiter_pkg.sv
// Shared definitions for the SD read arbiter slice: FSM states, block size, address width.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    STREAM,
    DONE,
    DRAIN
  } sd_state_e;

  localparam int unsigned SD_BLOCK_BYTES = 512;
  localparam int unsigned SD_ADDR_W      = 32;

endpackage

// File: rtl/sd_read_arbiter_if.sv
// Client + SDIF signal bundle for sd_read_arbiter; master = arbiter side, slave = clients/SDIF side.
interface sd_read_arbiter_if;

  logic                         req0;
  logic [sd_pkg::SD_ADDR_W-1:0] addr0;
  logic                         gnt0;
  logic                         req1;
  logic [sd_pkg::SD_ADDR_W-1:0] addr1;
  logic                         gnt1;
  logic [7:0]                   rd_byte;
  logic                         rd_valid;
  logic                         rd_last;
  logic                         rd_owner;
  logic                         done;
  logic                         err;
  logic [sd_pkg::SD_ADDR_W-1:0] sd_addr;
  logic                         sd_begin;
  logic                         sd_idle;
  logic                         sd_valid;
  logic [7:0]                   sd_byte;

  modport master (
    input  req0, addr0, req1, addr1, sd_idle, sd_valid, sd_byte,
    output gnt0, gnt1, rd_byte, rd_valid, rd_last, rd_owner, done, err, sd_addr, sd_begin
  );

  modport slave (
    output req0, addr0, req1, addr1, sd_idle, sd_valid, sd_byte,
    input  gnt0, gnt1, rd_byte, rd_valid, rd_last, rd_owner, done, err, sd_addr, sd_begin
  );

endinterface

// File: rtl/sd_read_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the non-last owner.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       win,
  output logic       valid
);

  always_comb begin
    valid = |req;
    win   = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_owner;
      default: win = 1'b0;
    endcase
  end

endmodule

// File: rtl/sd_read_arbiter.sv
// Shares the SD SPI block reader between two clients and forwards each 512-byte block.
// Optional watchdog enabled by defining SD_ARB_TIMEOUT_EN.
module sd_read_arbiter
  import sd_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = SD_BLOCK_BYTES
`ifdef SD_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic              clock,
  input  logic              reset,
  sd_read_arbiter_if.master bus
);

  localparam int unsigned CNT_W = $clog2(BLOCK_BYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);

  sd_state_e        state;
  logic [CNT_W-1:0] count;
  logic             short_blk;
  logic             last_owner;
  logic             pick_idx;
  logic             pick_valid;

  rr_arb2 u_arb (
    .req       ({bus.req1, bus.req0}),
    .last_owner(last_owner),
    .win       (pick_idx),
    .valid     (pick_valid)
  );

`ifdef SD_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  // Counter is loaded with 1 on the byte edge, so hitting TIMEOUT_CYCLES-1 puts
  // the done pulse exactly TIMEOUT_CYCLES edges after the last sd_valid.
  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      short_blk    <= 1'b0;
      last_owner   <= 1'b1;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.sd_begin <= 1'b0;
      bus.sd_addr  <= '0;
      bus.rd_byte  <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_last  <= 1'b0;
      bus.rd_owner <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
      wd_cnt       <= '0;
`endif
    end else begin
      bus.sd_begin <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_last  <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sd_idle && pick_valid) begin
            bus.sd_addr  <= pick_idx ? bus.addr1 : bus.addr0;
            bus.gnt0     <= ~pick_idx;
            bus.gnt1     <= pick_idx;
            bus.rd_owner <= pick_idx;
            last_owner   <= pick_idx;
            bus.sd_begin <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_START;
`ifdef SD_ARB_TIMEOUT_EN
          wd_cnt <= WD_W'(1);
`endif
        end
        WAIT_START: begin
          if (!bus.sd_idle) begin
            count <= '0;
            state <= STREAM;
          end
`ifdef SD_ARB_TIMEOUT_EN
          else if (wd_hit) begin
            short_blk <= 1'b1;
            state     <= DONE;
          end
          wd_cnt <= wd_cnt + 1'b1;
`endif
        end
        STREAM: begin
          if (bus.sd_valid) begin
            bus.rd_byte  <= bus.sd_byte;
            bus.rd_valid <= 1'b1;
            count        <= count + 1'b1;
            if (count == LAST_IDX) begin
              bus.rd_last <= 1'b1;
              state       <= DONE;
            end else if (bus.sd_idle) begin
              short_blk <= 1'b1;
              state     <= DONE;
            end
          end else if (bus.sd_idle) begin
            short_blk <= 1'b1;
            state     <= DONE;
          end
`ifdef SD_ARB_TIMEOUT_EN
          else if (wd_hit) begin
            short_blk <= 1'b1;
            state     <= DONE;
          end
          wd_cnt <= bus.sd_valid ? WD_W'(1) : wd_cnt + 1'b1;
`endif
        end
        DONE: begin
          bus.done  <= 1'b1;
          bus.err   <= short_blk;
          bus.gnt0  <= 1'b0;
          bus.gnt1  <= 1'b0;
          count     <= '0;
          short_blk <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
          wd_cnt    <= '0;
`endif
          state     <= DRAIN;
        end
        DRAIN: begin
          if (bus.sd_idle) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Randomized bench for sd_read_arbiter: SDIF behavioural model, byte scoreboard, arbitration reference.
module tb_sd_read_arbiter;

  localparam int BLK = 512;
`ifdef SD_ARB_TIMEOUT_EN
  localparam int TMO = 1000;
`endif

  logic clock;
  logic reset;
  sd_read_arbiter_if bus();

  sd_read_arbiter #(
    .BLOCK_BYTES(BLK)
`ifdef SD_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  longint cyc = 0;

  // SDIF model controls and state
  int cfg_len = BLK;
  bit cfg_short = 0, cfg_stall = 0, m_abort = 0, m_release = 0;
  int m_state = 0, m_lat = 0, m_gap = 0, m_sent = 0, m_tail = 0;
  longint last_sdv_cyc = 0;

  // monitor observations
  int grant_cnt = 0, done_cnt = 0, begin_cnt = 0, both_cnt = 0, gnt_lost = 0, stray_err = 0;
  bit cap_owner = 0, done_err = 0, gnt_prev = 0;
  logic [31:0] cap_addr = '0;
  longint done_cyc = 0;
  logic [7:0] rx_b[$];
  bit rx_o[$];
  bit rx_l[$];

  bit ref_last = 1;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_winner(input bit r0, input bit r1, input bit last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  // SDIF: idle until begin, latency, bytes with random gaps, then idle again
  initial begin
    bus.sd_idle = 1; bus.sd_valid = 0; bus.sd_byte = '0;
    forever begin
      @(negedge clock);
      bus.sd_valid = 0;
      if (m_abort) begin
        m_abort = 0; m_state = 0; bus.sd_idle = 1;
      end else begin
        case (m_state)
          0: begin
            bus.sd_idle = 1;
            if (bus.sd_begin === 1'b1) begin
              m_lat = $urandom_range(1, 3); m_state = 1;
            end
          end
          1: begin
            m_lat--;
            if (m_lat == 0) begin
              bus.sd_idle = 0; m_sent = 0; m_gap = $urandom_range(0, 2); m_state = 2;
            end
          end
          2: begin
            if (m_sent == cfg_len) begin
              if (cfg_stall) m_state = 4;
              else if (cfg_short) begin bus.sd_idle = 1; m_state = 0; end
              else begin m_tail = $urandom_range(1, 3); m_state = 3; end
            end else if (m_gap > 0) begin
              m_gap--;
            end else begin
              bus.sd_valid = 1; bus.sd_byte = 8'(m_sent);
              m_sent++; m_gap = $urandom_range(0, 2);
              last_sdv_cyc = cyc + 1;
            end
          end
          3: begin
            m_tail--;
            if (m_tail == 0) begin bus.sd_idle = 1; m_state = 0; end
          end
          default: begin
            if (m_release) begin bus.sd_idle = 1; m_state = 0; end
          end
        endcase
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (bus.gnt0 && bus.gnt1) both_cnt++;
    if (bus.sd_begin) begin_cnt++;
    if ((bus.gnt0 || bus.gnt1) && !gnt_prev) begin
      grant_cnt++; cap_owner = bus.gnt1; cap_addr = bus.sd_addr;
    end
    gnt_prev = bus.gnt0 || bus.gnt1;
    if (bus.rd_valid) begin
      rx_b.push_back(bus.rd_byte); rx_o.push_back(bus.rd_owner); rx_l.push_back(bus.rd_last);
      if (!(bus.gnt0 || bus.gnt1)) gnt_lost++;
    end
    if (bus.done) begin done_cnt++; done_err = bus.err; done_cyc = cyc; end
    if (bus.err && !bus.done) stray_err++;
  end

  task automatic clear_rx();
    rx_b.delete(); rx_o.delete(); rx_l.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_gnt0"}, bus.gnt0, 0);
    check_eq({tag, "_gnt1"}, bus.gnt1, 0);
    check_eq({tag, "_sd_begin"}, bus.sd_begin, 0);
    check_eq({tag, "_rd_valid"}, bus.rd_valid, 0);
    check_eq({tag, "_rd_last"}, bus.rd_last, 0);
    check_eq({tag, "_done"}, bus.done, 0);
    check_eq({tag, "_err"}, bus.err, 0);
    check_eq({tag, "_sd_addr"}, bus.sd_addr, 0);
    check_eq({tag, "_rd_byte"}, bus.rd_byte, 0);
    check_eq({tag, "_rd_owner"}, bus.rd_owner, 0);
  endtask

  // drop_at: -1 drop both reqs at grant, -2 keep them, >0 drop after that many bytes
  task automatic run_block(input string tag, input bit exp_owner, input logic [31:0] exp_addr,
                           input int exp_len, input bit exp_err, input int drop_at);
    int g0, d0, b0, k, bad;
    logic [31:0] s0, s1;
    g0 = grant_cnt; d0 = done_cnt; b0 = begin_cnt;
    clear_rx();
    k = 0;
    while (grant_cnt == g0 && k < 500) begin @(posedge clock); #2; k++; end
    if (grant_cnt == g0) begin check_eq({tag, "_grant_wait"}, 0, 1); return; end
    check_eq({tag, "_owner"}, cap_owner, exp_owner);
    check_eq({tag, "_sd_addr"}, cap_addr, exp_addr);
    s0 = bus.addr0; s1 = bus.addr1;
    bus.addr0 = $urandom; bus.addr1 = $urandom;
    if (drop_at == -1) begin bus.req0 = 0; bus.req1 = 0; end
    k = 0;
    while (done_cnt == d0 && k < 5000) begin
      @(posedge clock); #2; k++;
      if (drop_at > 0 && rx_b.size() >= drop_at) begin bus.req0 = 0; bus.req1 = 0; end
    end
    bus.addr0 = s0; bus.addr1 = s1;
    if (done_cnt == d0) begin check_eq({tag, "_done_wait"}, 0, 1); return; end
    check_eq({tag, "_len"}, rx_b.size(), exp_len);
    bad = 0;
    foreach (rx_b[i]) begin
      if (rx_b[i] !== 8'(i)) bad++;
      if (rx_o[i] !== exp_owner) bad++;
      if (rx_l[i] !== (i == BLK - 1)) bad++;
    end
    check_eq({tag, "_bytes_bad"}, bad, 0);
    check_eq({tag, "_err"}, done_err, exp_err);
    check_eq({tag, "_begins"}, begin_cnt - b0, 1);
    check_eq({tag, "_addr_hold"}, bus.sd_addr, exp_addr);
    ref_last = exp_owner;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("reset");
    #1;
    reset = 0;
    ref_last = 1;
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: got running expected finished");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int k, d0;
    logic [1:0] r;
    bit eo;
    reset = 1;
    bus.req0 = 0; bus.req1 = 0; bus.addr0 = '0; bus.addr1 = '0;
    do_reset();

    // single request
    bus.addr0 = 32'h200; bus.req0 = 1;
    run_block("single", 0, 32'h200, BLK, 0, -1);
    repeat (5) @(posedge clock); #2;

    // simultaneous requests from reset
    reset = 1;
    bus.addr0 = 32'h0; bus.addr1 = 32'h400; bus.req0 = 1; bus.req1 = 1;
    do_reset();
    run_block("tie_a", exp_winner(1, 1, ref_last), 32'h0, BLK, 0, -2);
    run_block("tie_b", exp_winner(1, 1, ref_last), 32'h400, BLK, 0, -2);
    run_block("tie_c", exp_winner(1, 1, ref_last), 32'h0, BLK, 0, -1);
    repeat (5) @(posedge clock); #2;

    // request dropped mid-block
    bus.addr1 = $urandom; bus.req1 = 1;
    run_block("drop", 1, bus.addr1, BLK, 0, 10);
    repeat (5) @(posedge clock); #2;

    // short block
    cfg_len = 100; cfg_short = 1;
    bus.addr0 = $urandom; bus.req0 = 1;
    run_block("short", 0, bus.addr0, 100, 1, -1);
    cfg_len = BLK; cfg_short = 0;
    repeat (5) @(posedge clock); #2;

    // reset during STREAM at byte 300
    clear_rx();
    d0 = done_cnt;
    bus.addr0 = $urandom; bus.req0 = 1;
    k = 0;
    while (rx_b.size() < 300 && k < 3000) begin @(posedge clock); #2; k++; end
    check_eq("midrst_reach300", rx_b.size() >= 300, 1);
    reset = 1; m_abort = 1; bus.req0 = 0;
    @(posedge clock); #1;
    check_reset_vals("midrst");
    reset = 0; ref_last = 1;
    repeat (20) @(posedge clock); #2;
    check_eq("midrst_no_done", done_cnt - d0, 0);
    bus.addr1 = $urandom; bus.req1 = 1;
    run_block("after_rst", 1, bus.addr1, BLK, 0, -1);

    // randomized request patterns
    for (int b = 0; b < 6; b++) begin
      repeat ($urandom_range(0, 4)) @(posedge clock);
      #2;
      r = 2'($urandom_range(1, 3));
      bus.addr0 = $urandom; bus.addr1 = $urandom;
      bus.req0 = r[0]; bus.req1 = r[1];
      eo = exp_winner(r[0], r[1], ref_last);
      run_block("rand", eo, eo ? bus.addr1 : bus.addr0, BLK, 0, -1);
    end

`ifdef SD_ARB_TIMEOUT_EN
    // watchdog: SDIF stalls mid-stream
    repeat (5) @(posedge clock); #2;
    cfg_len = 50; cfg_stall = 1;
    clear_rx();
    d0 = done_cnt;
    bus.addr0 = $urandom; bus.req0 = 1;
    k = 0;
    while (done_cnt == d0 && k < 5000) begin
      @(posedge clock); #2; k++;
      if (bus.gnt0) bus.req0 = 0;
    end
    m_release = 1;
    check_eq("wd_done_seen", done_cnt - d0, 1);
    check_eq("wd_latency", done_cyc - last_sdv_cyc, TMO);
    check_eq("wd_err", done_err, 1);
    check_eq("wd_len", rx_b.size(), 50);
    repeat (5) @(posedge clock); #2;
    m_release = 0; cfg_stall = 0; cfg_len = BLK;
`endif

    repeat (10) @(posedge clock); #2;
    check_eq("gnt_exclusive", both_cnt, 0);
    check_eq("gnt_held_bytes", gnt_lost, 0);
    check_eq("err_without_done", stray_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sd_read_arbiter.md
Name: sd_read_arbiter

Overview:
- Sequences single-block reads on the SD SPI interface (SDIF) and shares it between two requesters, e.g. a PRG/CHR loader and a save-RAM loader.
- Accepts an address and request from each client and grants one client at a time.
- Pulses SDIF's begin_read, then forwards the 512-byte stream tagged with owner, last-byte and done.
- Sits between the loaders and SDIF; SDIF's own reset stays with the top level.

Parameters:
- BLOCK_BYTES, 512: bytes per read; the byte counter is clog2(BLOCK_BYTES)+1 bits wide.
- TIMEOUT_CYCLES, 1048576: watchdog limit, used only with the optional feature.

Ports:
- clock  in  1  system clock (same clock as SDIF)
- reset  in  1  synchronous, active-high
- req0  in  1  client 0 request (level)
- addr0  in  32  client 0 read address; passed verbatim to SDIF
- gnt0  out  1  client 0 owns the interface
- req1  in  1  client 1 request (level)
- addr1  in  32  client 1 read address
- gnt1  out  1  client 1 owns the interface
- rd_byte  out  8  forwarded data byte
- rd_valid  out  1  rd_byte valid, one cycle per byte
- rd_last  out  1  high with the final rd_valid of the block
- rd_owner  out  1  owner of the current byte (0/1)
- done  out  1  one-cycle pulse at end of a block
- err  out  1  one-cycle pulse with done if the block was short or aborted
- sd_addr  out  32  to SDIF in_addr
- sd_begin  out  1  to SDIF begin_read
- sd_idle  in  1  from SDIF idle
- sd_valid  in  1  from SDIF valid_read
- sd_byte  in  8  from SDIF sd_byte

Behaviour:
- Reset: state=IDLE; gnt0, gnt1, sd_begin, rd_valid, rd_last, done and err are 0; sd_addr=0; rd_byte=0; rd_owner=0; last_owner=1, so client 0 wins the first tie.
- IDLE:
  - If sd_idle=1 and any req is high, pick the owner.
  - Only one req high: that client. Both high: the client that is not last_owner.
  - Register sd_addr from the owner's addr, assert that gnt, set last_owner, go to ISSUE.
  - If sd_idle=0, stay in IDLE.
- ISSUE: sd_begin=1 for exactly one cycle; go to WAIT_START.
- WAIT_START:
  - Hold until sd_idle=0, which means SDIF accepted the command; then go to STREAM with count=0.
  - sd_valid is ignored here.
- STREAM:
  - Each sd_valid=1 registers rd_byte<=sd_byte and rd_valid=1 with rd_owner, giving 1-cycle latency. Increment count.
  - On the byte where count reaches BLOCK_BYTES-1: rd_last=1, go to DONE.
  - If sd_idle rises before the full count: go to DONE with a short flag set.
- DONE:
  - Pulse done for one cycle; err=short flag.
  - Drop gnt; clear count and flag.
  - Go to DRAIN.
- DRAIN:
  - Ignore and do not forward any sd_valid.
  - Wait for sd_idle=1, then go to IDLE.
  - This is the earliest point a new grant can happen, so there are at least 2 idle cycles between blocks.
- Grant and address stability: gnt is held from grant through DONE even if the req drops. A dropped req does not abort the transfer; all bytes are still delivered.
- Address sampling: sd_addr is sampled only at grant; later changes to addrN are ignored.
- Requests arriving mid-transfer wait in IDLE arbitration. Strict alternation applies while both are asserted.
- Reset mid-operation: everything returns to reset values on the next edge and no done is issued. sd_begin must never be high outside ISSUE.

Optional Feature:
- SD_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_START and STREAM and clears on every sd_valid.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err=1.
  - DRAIN then waits for sd_idle as normal.
- Undefined: no watchdog logic. err is driven only by the short-block condition.

Decomposition:
- Shared package sd_pkg holds:
  - state encoding constants: IDLE, ISSUE, WAIT_START, STREAM, DONE, DRAIN;
  - SD_BLOCK_BYTES=512;
  - SD_ADDR_W=32.
- One sub-module: rr_arb2, a 2-way round-robin picker. Inputs req[1:0] and last_owner; outputs the winning index and a valid flag.

Test Plan:
- Single request: req0=1, addr0=32'h200; SDIF model streams 512 bytes 0x00..0xFF repeating.
  - Required: sd_addr=32'h200, one sd_begin pulse, 512 rd_valid with rd_owner=0, rd_last on the 512th byte, then done=1 and err=0.
- Simultaneous requests: req0 and req1 both high from reset with addr0=32'h0, addr1=32'h400.
  - Required: client 0 is served first, then client 1 (sd_addr=32'h400), then client 0 again. gnt0 and gnt1 are never high together.
- Request dropped: req1 falls after 10 bytes.
  - Required: all 512 bytes are still forwarded with rd_owner=1, and done pulses.
- Short block: model raises sd_idle after 100 bytes.
  - Required: 100 rd_valid, no rd_last, done=1 with err=1, return to IDLE.
- Reset mid-operation: reset for 1 cycle during STREAM at byte 300.
  - Required: all outputs at reset values the next cycle, no done; a new request afterwards completes normally.
- Watchdog (SD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=1000): model stalls in STREAM.
  - Required: done=1 with err=1 exactly 1000 cycles after the last sd_valid.
